// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the icache/dcache memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_I = 1'b0;
  localparam req_id_t REQ_D = 1'b1;

  function automatic logic [1:0] id_onehot(input req_id_t id);
    return (id == REQ_D) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of mem_arbiter; master is the arbiter's view,
// slave is the view of whatever drives the requesters and the memory system.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_we;
  logic [DATA_W-1:0] i_req_wdata;
  logic [MASK_W-1:0] i_req_wmask;
  logic              i_resp_valid;
  logic [DATA_W-1:0] i_resp_data;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_req_we;
  logic [DATA_W-1:0] d_req_wdata;
  logic [MASK_W-1:0] d_req_wmask;
  logic              d_resp_valid;
  logic [DATA_W-1:0] d_resp_data;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_we;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [MASK_W-1:0] mem_req_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  logic              busy;
  logic              grant_d;

  modport master (
    input  i_req_valid, i_req_addr, i_req_we, i_req_wdata, i_req_wmask,
    output i_req_ready, i_resp_valid, i_resp_data,
    input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wmask,
    output d_req_ready, d_resp_valid, d_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output busy, grant_d
  );

  modport slave (
    output i_req_valid, i_req_addr, i_req_we, i_req_wdata, i_req_wmask,
    input  i_req_ready, i_resp_valid, i_resp_data,
    output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wmask,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  busy, grant_d
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last_grant,
  output logic [1:0] grant,
  output req_id_t    winner
);

  always_comb begin
    winner = REQ_I;
    grant  = '0;
    if (valid == 2'b11) begin
      winner = (last_grant == REQ_D) ? REQ_I : REQ_D;
    end else if (valid[1]) begin
      winner = REQ_D;
    end
    if (valid != 2'b00) begin
      grant = id_onehot(winner);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between icache and dcache miss paths, one
// transaction in flight, round-robin on ties, read data routed back to its owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  localparam int MASK_W = DATA_W / 8;

  state_t            state;
  req_id_t           last_grant;
  logic              grant_d_q;
  logic              idle;
  logic [1:0]        grant;
  req_id_t           winner;

  logic              req_valid_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              req_we_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [MASK_W-1:0] req_wmask_q;

  logic [DATA_W-1:0] resp_data_q;
  logic              i_resp_valid_q;
  logic              d_resp_valid_q;

  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic [MASK_W-1:0] sel_wmask;

  rr_arb2 u_rr_arb2 (
    .valid      ({bus.d_req_valid, bus.i_req_valid}),
    .last_grant (last_grant),
    .grant      (grant),
    .winner     (winner)
  );

  // Ready is combinational in IDLE only; suppressed while reset is held.
  assign idle            = (state == IDLE);
  assign bus.i_req_ready = idle & ~rst & grant[0];
  assign bus.d_req_ready = idle & ~rst & grant[1];

  always_comb begin
    if (winner == REQ_D) begin
      sel_addr  = bus.d_req_addr;
      sel_we    = bus.d_req_we;
      sel_wdata = bus.d_req_wdata;
      sel_wmask = bus.d_req_wmask;
    end else begin
      sel_addr  = bus.i_req_addr;
      sel_we    = bus.i_req_we;
      sel_wdata = bus.i_req_wdata;
      sel_wmask = bus.i_req_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= REQ_I;
      grant_d_q      <= 1'b0;
      req_valid_q    <= 1'b0;
      req_addr_q     <= '0;
      req_we_q       <= 1'b0;
      req_wdata_q    <= '0;
      req_wmask_q    <= '0;
      resp_data_q    <= '0;
      i_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;
    end else begin
      i_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            req_addr_q  <= sel_addr;
            req_we_q    <= sel_we;
            req_wdata_q <= sel_wdata;
            req_wmask_q <= sel_wmask;
            req_valid_q <= 1'b1;
            grant_d_q   <= winner;
            last_grant  <= winner;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            state       <= req_we_q ? IDLE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (bus.mem_resp_valid) begin
            resp_data_q    <= bus.mem_resp_data;
            i_resp_valid_q <= ~grant_d_q;
            d_resp_valid_q <= grant_d_q;
            state          <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_we    = req_we_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_req_wmask = req_wmask_q;
  assign bus.i_resp_valid  = i_resp_valid_q;
  assign bus.d_resp_valid  = d_resp_valid_q;
  assign bus.i_resp_data   = resp_data_q;
  assign bus.d_resp_data   = resp_data_q;
  assign bus.busy          = ~idle;
  assign bus.grant_d       = grant_d_q;

  a_ready_only_idle: assert property (@(posedge clk) disable iff (rst)
    (bus.i_req_ready || bus.d_req_ready) |-> idle);

  a_resp_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(bus.i_resp_valid && bus.d_resp_valid));

  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.mem_req_valid && !bus.mem_req_ready) |=>
      (bus.mem_req_valid && $stable(bus.mem_req_addr) && $stable(bus.mem_req_we)
       && $stable(bus.mem_req_wdata) && $stable(bus.mem_req_wmask)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: read responses are predicted at accept time
// and matched against owner/data when a resp_valid pulse appears.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic        own;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb_q[$];
  logic rr_exp[$];
  int   acc_cyc[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h0000_1000) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.i_resp_valid === 1'b1 || bus.d_resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("resp_unexpected", {bus.d_resp_valid, bus.i_resp_valid}, 2'b00);
      end else begin
        e = sb_q.pop_front();
        check("resp_owner", {bus.d_resp_valid, bus.i_resp_valid}, e.own ? 2'b10 : 2'b01);
        check("resp_data", e.own ? bus.d_resp_data : bus.i_resp_data, e.data);
        check("resp_data_shared", bus.i_resp_data, bus.d_resp_data);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue_req(input logic d, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, input logic [3:0] wmask, input bit push);
    logic rdy;
    logic other;
    if (d) begin
      bus.d_req_valid = 1'b1; bus.d_req_addr = addr; bus.d_req_we = we;
      bus.d_req_wdata = wdata; bus.d_req_wmask = wmask;
    end else begin
      bus.i_req_valid = 1'b1; bus.i_req_addr = addr; bus.i_req_we = we;
      bus.i_req_wdata = wdata; bus.i_req_wmask = wmask;
    end
    rdy = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #1;
      rdy = d ? bus.d_req_ready : bus.i_req_ready;
      if (rdy === 1'b1) break;
      @(negedge clk);
    end
    check("accept_seen", rdy, 1'b1);
    if (rdy !== 1'b1) begin
      if (d) bus.d_req_valid = 1'b0; else bus.i_req_valid = 1'b0;
      return;
    end
    other = d ? bus.i_req_ready : bus.d_req_ready;
    check("loser_ready", other, 1'b0);
    acc_cyc.push_back(cyc);
    if (rr_exp.size() != 0) check("rr_order", d, rr_exp.pop_front());
    if (push && !we) sb_q.push_back('{own: d, data: mem_val(addr)});
    @(negedge clk);
    check("req_valid_next", bus.mem_req_valid, 1'b1);
    check("req_addr", bus.mem_req_addr, addr);
    check("req_we", bus.mem_req_we, we);
    check("req_wdata", bus.mem_req_wdata, wdata);
    check("req_wmask", bus.mem_req_wmask, wmask);
    check("grant_d", bus.grant_d, d);
    check("busy_issue", bus.busy, 1'b1);
    if (d) bus.d_req_valid = 1'b0; else bus.i_req_valid = 1'b0;
  endtask

  task automatic mem_serve(input int stall, input int lat);
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic        w;
    logic        own;
    int          k;
    k = 0;
    @(negedge clk);
    while (bus.mem_req_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("mem_req_seen", bus.mem_req_valid, 1'b1);
    if (bus.mem_req_valid !== 1'b1) return;
    a = bus.mem_req_addr; w = bus.mem_req_we; wd = bus.mem_req_wdata; wm = bus.mem_req_wmask;
    own = bus.grant_d;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", bus.mem_req_valid, 1'b1);
      check("stall_addr", bus.mem_req_addr, a);
      check("stall_we", bus.mem_req_we, w);
      check("stall_wdata", bus.mem_req_wdata, wd);
      check("stall_wmask", bus.mem_req_wmask, wm);
    end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check("req_dropped", bus.mem_req_valid, 1'b0);
    if (w) begin
      check("wr_idle_next", bus.busy, 1'b0);
      return;
    end
    check("rd_wait_busy", bus.busy, 1'b1);
    repeat (lat - 1) @(negedge clk);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = mem_val(a);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    check("resp_latency", own ? bus.d_resp_valid : bus.i_resp_valid, 1'b1);
    check("resp_busy", bus.busy, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req_valid = 1'b1; bus.i_req_addr = '0; bus.i_req_we = 1'b0;
    bus.i_req_wdata = '0;   bus.i_req_wmask = '0;
    bus.d_req_valid = 1'b1; bus.d_req_addr = '0; bus.d_req_we = 1'b0;
    bus.d_req_wdata = '0;   bus.d_req_wmask = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_i_ready", bus.i_req_ready, 1'b0);
    check("rst_d_ready", bus.d_req_ready, 1'b0);
    check("rst_resp_valid", {bus.d_resp_valid, bus.i_resp_valid}, 2'b00);
    check("rst_mem_valid", bus.mem_req_valid, 1'b0);
    check("rst_mem_fields", {bus.mem_req_addr, bus.mem_req_wdata},  64'h0);
    check("rst_mem_we_mask", {bus.mem_req_we, bus.mem_req_wmask}, 5'h0);
    check("rst_resp_data", bus.i_resp_data, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_grant_d", bus.grant_d, 1'b0);
    bus.i_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    rst = 1'b0;

    // Both requesters streaming reads from reset: D, I, D, I at 4-cycle spacing.
    rr_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
    acc_cyc.delete();
    fork
      begin
        issue_req(1'b0, 32'h0000_2000, 1'b0, 32'h0, 4'h0, 1'b1);
        issue_req(1'b0, 32'h0000_2004, 1'b0, 32'h0, 4'h0, 1'b1);
      end
      begin
        issue_req(1'b1, 32'h0000_3000, 1'b0, 32'h0, 4'h0, 1'b1);
        issue_req(1'b1, 32'h0000_3004, 1'b0, 32'h0, 4'h0, 1'b1);
      end
      begin
        repeat (4) mem_serve(0, 1);
      end
    join
    check("rr_count", acc_cyc.size(), 4);
    for (int k = 1; k < acc_cyc.size(); k++) begin
      check("rr_turnaround", acc_cyc[k] - acc_cyc[k-1], 4);
    end

    // Single icache read, memory latency 3.
    fork
      issue_req(1'b0, 32'h0000_1000, 1'b0, 32'h0, 4'h0, 1'b1);
      mem_serve(0, 3);
    join
    repeat (2) @(negedge clk);

    // dcache write with memory stalling 5 cycles; no response expected.
    fork
      issue_req(1'b1, 32'h0000_0010, 1'b1, 32'h1234_5678, 4'b0011, 1'b1);
      mem_serve(5, 0);
    join
    repeat (3) begin
      @(negedge clk);
      check("wr_no_resp", {bus.d_resp_valid, bus.i_resp_valid}, 2'b00);
    end

    // Spurious memory response in IDLE must not disturb anything.
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    @(negedge clk);
    check("spur_busy", bus.busy, 1'b0);
    check("spur_data_hold", bus.i_resp_data, 32'hDEAD_BEEF);
    fork
      issue_req(1'b1, 32'h0000_0080, 1'b0, 32'h0, 4'h0, 1'b1);
      mem_serve(0, 2);
    join
    repeat (2) @(negedge clk);

    // Reset while waiting for read data; the late data must be dropped.
    fork
      issue_req(1'b0, 32'h0000_4000, 1'b0, 32'h0, 4'h0, 1'b0);
      begin : accept_only
        int k;
        k = 0;
        @(negedge clk);
        while (bus.mem_req_valid !== 1'b1 && k < 200) begin
          @(negedge clk);
          k++;
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
      end
    join
    check("rstmid_busy_before", bus.busy, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h5555_AAAA;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    repeat (2) begin
      @(negedge clk);
      check("rstmid_resp_valid", {bus.d_resp_valid, bus.i_resp_valid}, 2'b00);
    end
    check("rstmid_busy", bus.busy, 1'b0);
    check("rstmid_grant_d", bus.grant_d, 1'b0);
    check("rstmid_mem_valid", bus.mem_req_valid, 1'b0);
    check("rstmid_mem_addr", bus.mem_req_addr, 32'h0);
    check("rstmid_resp_data", bus.i_resp_data, 32'h0);

    repeat (3) @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
